// File: rtl/ram32_scan_reader_pkg.sv
// ram32_scan_reader_pkg
//   Shared definitions for the RAM32 scan reader: RAM geometry constants
//   and the reader state type.
package ram32_scan_reader_pkg;

    localparam int unsigned RAM32_AW    = 5;
    localparam int unsigned RAM32_DEPTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/ram32_scan_reader_if.sv
// ram32_scan_reader_if
//   Bundles the scan request, RAM address/data and result handshake.
//   slave  : the scan reader (drives ADR/SEL/BUSY/DOUT/DVALID)
//   master : the requester / RAM side (drives START/BASE/LEN/RAM_O/DREADY)
//   START  - scan request, taken only when the reader is idle
//   BASE   - first RAM address of the scan
//   LEN    - bit count 1..32, 0 means 32
//   BUSY   - reader is scanning or holding a result
//   SEL    - reader owns the RAM address lines
//   ADR    - registered RAM address
//   RAM_O  - combinational RAM read data
//   DOUT   - packed result word
//   DVALID - result valid
//   DREADY - consumer accepts the result
interface ram32_scan_reader_if;
    import ram32_scan_reader_pkg::*;

    logic                       START;
    logic [RAM32_AW-1:0]        BASE;
    logic [RAM32_AW:0]          LEN;
    logic                       BUSY;
    logic                       SEL;
    logic [RAM32_AW-1:0]        ADR;
    logic                       RAM_O;
    logic [RAM32_DEPTH-1:0]     DOUT;
    logic                       DVALID;
    logic                       DREADY;

    modport slave (
        input  START, BASE, LEN, RAM_O, DREADY,
        output BUSY, SEL, ADR, DOUT, DVALID
    );

    modport master (
        output START, BASE, LEN, RAM_O, DREADY,
        input  BUSY, SEL, ADR, DOUT, DVALID
    );

endinterface

// File: rtl/ram32_scan_reader.sv
// ram32_scan_reader
//   Sweeps a RAM32x1 address range starting at BASE for LEN bits, samples
//   the combinational RAM output once per cycle and packs the bits into a
//   32-bit word delivered on a valid/ready handshake.
//   Parameter MSB_FIRST: 0 = bit at offset k lands in DOUT[k],
//                        1 = it lands in DOUT[LEN-1-k].
//   Ports:
//     CLK  - clock, rising edge
//     RSTN - asynchronous active-low reset
//     bus  - scan/RAM/result signals (slave modport)
module ram32_scan_reader
    import ram32_scan_reader_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                CLK,
    input  logic                RSTN,
    ram32_scan_reader_if.slave  bus
);

    state_t                 r_state;
    logic [RAM32_AW-1:0]    r_adr;
    logic [RAM32_AW:0]      r_cnt;
    logic [RAM32_AW:0]      r_len;
    logic [RAM32_DEPTH-1:0] r_dout;
    logic                   r_dvalid;

    logic [RAM32_AW:0]      w_len_eff;
    logic [RAM32_AW-1:0]    w_rev;
    logic [RAM32_AW-1:0]    w_bitpos;
    logic                   w_last;

    // LEN of 0 encodes a full 32-bit sweep.
    assign w_len_eff = (bus.LEN == '0) ? 6'd32 : bus.LEN;

    // Reversed position computed modulo 32: for LEN=32 the low bits of
    // r_len are 0, so 0-1-cnt wraps to 31-cnt as required.
    assign w_rev    = r_len[RAM32_AW-1:0] - 5'd1 - r_cnt[RAM32_AW-1:0];
    assign w_bitpos = MSB_FIRST ? w_rev : r_cnt[RAM32_AW-1:0];
    assign w_last   = (r_cnt == (r_len - 6'd1));

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state  <= IDLE;
            r_adr    <= '0;
            r_cnt    <= '0;
            r_len    <= '0;
            r_dout   <= '0;
            r_dvalid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.START) begin
                        r_adr   <= bus.BASE;
                        r_cnt   <= '0;
                        r_len   <= w_len_eff;
                        r_dout  <= '0;
                        r_state <= SCAN;
                    end
                end
                SCAN: begin
                    r_dout[w_bitpos] <= bus.RAM_O;
                    r_adr            <= r_adr + 5'd1;
                    r_cnt            <= r_cnt + 6'd1;
                    if (w_last) begin
                        r_state  <= DONE;
                        r_dvalid <= 1'b1;
                    end
                end
                DONE: begin
                    if (r_dvalid && bus.DREADY) begin
                        r_dvalid <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.ADR    = r_adr;
    assign bus.SEL    = (r_state == SCAN);
    assign bus.BUSY   = (r_state != IDLE);
    assign bus.DOUT   = r_dout;
    assign bus.DVALID = r_dvalid;

endmodule

// File: tb/tb_ram32_scan_reader.sv
// tb_ram32_scan_reader
//   Directed bench for ram32_scan_reader: one DUT per packing order, each
//   paired with a RAM32x1 read model sharing one memory image.
module tb_ram32_scan_reader;
    import ram32_scan_reader_pkg::*;

    localparam logic [RAM32_DEPTH-1:0] INIT = 32'hA5C30F96;

    logic CLK;
    logic RSTN;
    logic [RAM32_DEPTH-1:0] mem;

    int errors = 0;
    int checks = 0;

    ram32_scan_reader_if if_l ();
    ram32_scan_reader_if if_m ();

    // RAM32x1 read ports: combinational output at the presented address.
    assign if_l.RAM_O = mem[if_l.ADR];
    assign if_m.RAM_O = mem[if_m.ADR];

    ram32_scan_reader #(.MSB_FIRST(1'b0)) u_lsb (
        .CLK  (CLK),
        .RSTN (RSTN),
        .bus  (if_l)
    );

    ram32_scan_reader #(.MSB_FIRST(1'b1)) u_msb (
        .CLK  (CLK),
        .RSTN (RSTN),
        .bus  (if_m)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [4:0] g_adr(input int d);
        return (d != 0) ? if_m.ADR : if_l.ADR;
    endfunction
    function automatic logic [31:0] g_dout(input int d);
        return (d != 0) ? if_m.DOUT : if_l.DOUT;
    endfunction
    function automatic logic [2:0] g_flags(input int d);
        // {BUSY, SEL, DVALID}
        return (d != 0) ? {if_m.BUSY, if_m.SEL, if_m.DVALID}
                        : {if_l.BUSY, if_l.SEL, if_l.DVALID};
    endfunction

    task automatic set_start(input int d, input logic v);
        if (d != 0) if_m.START = v;
        else        if_l.START = v;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Full scan on DUT d with DREADY high; checks address sequence, flags,
    // result timing and the handshake back to idle.
    task automatic do_scan(input int d, input logic [4:0] base,
                           input logic [5:0] len, input logic [31:0] exp,
                           input string name);
        int n;
        logic [4:0] ea;
        n = (len == 6'd0) ? 32 : int'(len);
        if_l.BASE = base; if_m.BASE = base;
        if_l.LEN  = len;  if_m.LEN  = len;
        if_l.DREADY = 1'b1; if_m.DREADY = 1'b1;
        set_start(d, 1'b1);
        tick();
        set_start(d, 1'b0);
        checks++;
        if (g_adr(d) !== base || g_flags(d) !== 3'b110) begin
            errors++;
            $display("FAIL %s.edge0: adr=%h flags=%b expected adr=%h flags=110",
                     name, g_adr(d), g_flags(d), base);
        end
        for (int k = 1; k <= n; k++) begin
            tick();
            if (k < n) begin
                ea = base + 5'(k);
                checks++;
                if (g_adr(d) !== ea || g_flags(d) !== 3'b110) begin
                    errors++;
                    $display("FAIL %s.scan%0d: adr=%h flags=%b expected adr=%h flags=110",
                             name, k, g_adr(d), g_flags(d), ea);
                end
            end else begin
                checks++;
                if (g_flags(d) !== 3'b101 || g_dout(d) !== exp) begin
                    errors++;
                    $display("FAIL %s.done: dout=%h flags=%b expected dout=%h flags=101",
                             name, g_dout(d), g_flags(d), exp);
                end
            end
        end
        tick();
        checks++;
        if (g_flags(d) !== 3'b000 || g_dout(d) !== exp) begin
            errors++;
            $display("FAIL %s.handshake: dout=%h flags=%b expected dout=%h flags=000",
                     name, g_dout(d), g_flags(d), exp);
        end
    endtask

    task automatic test_reset();
        RSTN = 1'b0;
        #3;
        checks++;
        if (g_flags(0) !== 3'b000 || g_adr(0) !== 5'd0 || g_dout(0) !== 32'd0 ||
            g_flags(1) !== 3'b000 || g_adr(1) !== 5'd0 || g_dout(1) !== 32'd0) begin
            errors++;
            $display("FAIL reset: lsb adr=%h dout=%h flags=%b msb adr=%h dout=%h flags=%b expected all 0",
                     g_adr(0), g_dout(0), g_flags(0), g_adr(1), g_dout(1), g_flags(1));
        end
        tick();
        RSTN = 1'b1;
        tick();
        checks++;
        if (g_flags(0) !== 3'b000 || g_flags(1) !== 3'b000) begin
            errors++;
            $display("FAIL reset.idle: lsb flags=%b msb flags=%b expected 000",
                     g_flags(0), g_flags(1));
        end
    endtask

    task automatic test_full_lsb();
        do_scan(0, 5'd0, 6'd0, 32'hA5C30F96, "full_lsb");
    endtask

    task automatic test_wrap();
        do_scan(0, 5'd30, 6'd4, 32'h0000000A, "wrap_lsb");
    endtask

    task automatic test_msb_first();
        do_scan(1, 5'd0, 6'd0, 32'h69F0C3A5, "full_msb");
        do_scan(1, 5'd30, 6'd4, 32'h00000005, "wrap_msb");
    endtask

    task automatic test_len1();
        do_scan(0, 5'd7, 6'd1, 32'h00000001, "len1");
    endtask

    task automatic test_backpressure();
        // BASE=3, LEN=8: mem[3..10] = 0,1,0,0,1,1,1,1 -> 8'hF2
        if_l.BASE = 5'd3; if_l.LEN = 6'd8; if_l.DREADY = 1'b0;
        if_l.START = 1'b1;
        tick();
        if_l.START = 1'b0;
        for (int k = 1; k <= 8; k++) tick();
        // Try to start another scan while the result is pending.
        if_l.START = 1'b1;
        if_l.BASE  = 5'd20;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (g_flags(0) !== 3'b101 || g_dout(0) !== 32'h000000F2 || g_adr(0) !== 5'd11) begin
                errors++;
                $display("FAIL backpressure.hold%0d: dout=%h flags=%b adr=%h expected dout=000000f2 flags=101 adr=0b",
                         c, g_dout(0), g_flags(0), g_adr(0));
            end
        end
        if_l.START  = 1'b0;
        if_l.DREADY = 1'b1;
        tick();
        checks++;
        if (g_flags(0) !== 3'b000 || g_dout(0) !== 32'h000000F2) begin
            errors++;
            $display("FAIL backpressure.release: dout=%h flags=%b expected dout=000000f2 flags=000",
                     g_dout(0), g_flags(0));
        end
        tick();
        checks++;
        if (g_flags(0) !== 3'b000 || g_adr(0) !== 5'd11) begin
            errors++;
            $display("FAIL backpressure.no_queue: flags=%b adr=%h expected flags=000 adr=0b",
                     g_flags(0), g_adr(0));
        end
    endtask

    task automatic test_reset_mid_scan();
        if_l.BASE = 5'd0; if_l.LEN = 6'd0; if_l.DREADY = 1'b1;
        if_l.START = 1'b1;
        tick();
        if_l.START = 1'b0;
        for (int k = 1; k <= 10; k++) tick();
        checks++;
        if (g_adr(0) !== 5'd10 || g_flags(0) !== 3'b110 || g_dout(0) !== 32'h00000396) begin
            errors++;
            $display("FAIL midreset.before: adr=%h dout=%h flags=%b expected adr=0a dout=00000396 flags=110",
                     g_adr(0), g_dout(0), g_flags(0));
        end
        #2;
        RSTN = 1'b0;
        #1;
        checks++;
        if (g_adr(0) !== 5'd0 || g_dout(0) !== 32'd0 || g_flags(0) !== 3'b000) begin
            errors++;
            $display("FAIL midreset.async: adr=%h dout=%h flags=%b expected all 0",
                     g_adr(0), g_dout(0), g_flags(0));
        end
        tick();
        RSTN = 1'b1;
        tick();
        // mem[5..7] = 0,0,1 -> 3'b100
        do_scan(0, 5'd5, 6'd3, 32'h00000004, "restart");
    endtask

    initial begin
        mem = INIT;
        RSTN = 1'b0;
        if_l.START = 1'b0; if_l.BASE = '0; if_l.LEN = '0; if_l.DREADY = 1'b0;
        if_m.START = 1'b0; if_m.BASE = '0; if_m.LEN = '0; if_m.DREADY = 1'b0;
        test_reset();
        test_full_lsb();
        test_wrap();
        test_msb_first();
        test_backpressure();
        test_reset_mid_scan();
        test_len1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
